freqm_counter: RTL and testbench

Parametrised multi-decade frequency meter core. It counts rising edges of an asynchronous input FX over a gate window of CLK cycles, then latches the BCD result into a display register with overflow status. It also scans the result out one digit at a time for a multiplexed 7-segment driver. It is the synchronous successor of the discrete 7490/74162, latch and 7442 frequency-meter chain, with selectable gate range, hold and overflow detection.

---
 rtl/freqm_counter_if.sv | 15 +
 rtl/freqm_counter.sv | 134 +++++++++++++
 tb/tb_freqm_counter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/freqm_counter_if.sv
// freqm_counter_if: measurement and display bus of the frequency meter core
interface freqm_counter_if #(
    parameter int DIGITS = 4
);
    logic                  FX;
    logic [1:0]            RANGE;
    logic                  HOLD;
    logic [4*DIGITS-1:0]   Q;
    logic                  OVF;
    logic                  RDY;
    logic [DIGITS-1:0]     DSEL;
    logic [3:0]            DIG;
    modport master (output FX, RANGE, HOLD, input Q, OVF, RDY, DSEL, DIG);
    modport slave  (input FX, RANGE, HOLD, output Q, OVF, RDY, DSEL, DIG);
endinterface

// File: rtl/freqm_counter.sv
// freqm_counter: multi-decade BCD frequency meter with gate FSM, latch and digit scan (FREQM_BLANK_EN adds leading-zero blanking)
module freqm_counter #(
    parameter int DIGITS   = 4,
    parameter int GATE_CYC = 1000,
    parameter int SCAN_DIV = 16
) (
    input  logic            CLK,
    input  logic            R0,
    freqm_counter_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int TW = $clog2(GATE_CYC * 100);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [1:0] S_GATE  = 2'd0;
    localparam logic [1:0] S_LATCH = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]        r_sync;
    logic              r_fx_q;
    logic [1:0]        r_state;
    logic [TW-1:0]     r_timer;
    logic [W-1:0]      r_cnt;
    logic              r_ovf;
    logic [W-1:0]      r_q;
    logic              r_ovf_q;
    logic              r_rdy;
    logic [DW-1:0]     r_div;
    logic [IW-1:0]     r_idx;
    logic [DIGITS-1:0] r_dsel;
    logic              w_edge;
    logic              w_carry;
    logic [W-1:0]      w_cnt_nxt;
    logic [TW-1:0]     w_gm1;
    logic              w_tc;
    logic [IW-1:0]     w_idx_nxt;
    logic [3:0]        w_dig_raw;

    assign w_edge = r_sync[1] & ~r_fx_q & (r_state == S_GATE);
    assign w_gm1  = (bus.RANGE == 2'd0) ? TW'(GATE_CYC - 1) :
                    (bus.RANGE == 2'd1) ? TW'(GATE_CYC * 10 - 1) : TW'(GATE_CYC * 100 - 1);

    // two-stage synchronizer plus previous-value register for rising-edge detection
    always_ff @(posedge CLK or posedge R0) begin
        if (R0) begin
            r_sync <= 2'b00;
            r_fx_q <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bus.FX};
            r_fx_q <= r_sync[1];
        end
    end

    // cascaded BCD increment; w_carry ends up set only when every decade is 9
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_carry   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_carry)
                w_cnt_nxt[4*k +: 4] = (r_cnt[4*k +: 4] == 4'd9) ? 4'd0 : r_cnt[4*k +: 4] + 4'd1;
            w_carry = w_carry & (r_cnt[4*k +: 4] == 4'd9);
        end
    end

    // gate / latch / clear sequencer with saturating counter and result register
    always_ff @(posedge CLK or posedge R0) begin
        if (R0) begin
            r_state <= S_CLEAR;
            r_timer <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_q     <= '0;
            r_ovf_q <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_GATE: begin
                    if (w_edge) begin
                        if (w_carry) r_ovf <= 1'b1;
                        else r_cnt <= w_cnt_nxt;
                    end
                    if (r_timer == '0) r_state <= S_LATCH;
                    else r_timer <= r_timer - TW'(1);
                end
                S_LATCH: begin
                    if (!bus.HOLD) begin
                        r_q     <= r_cnt;
                        r_ovf_q <= r_ovf;
                        r_rdy   <= 1'b1;
                    end
                    r_state <= S_CLEAR;
                end
                default: begin
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                    r_timer <= w_gm1;
                    r_state <= S_GATE;
                end
            endcase
        end
    end

    assign w_tc      = (r_div == DW'(SCAN_DIV - 1));
    assign w_idx_nxt = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);

    // scan divider advancing the digit index and the active-low select
    always_ff @(posedge CLK or posedge R0) begin
        if (R0) begin
            r_div  <= '0;
            r_idx  <= '0;
            r_dsel <= ~DIGITS'(1);
        end else if (w_tc) begin
            r_div  <= '0;
            r_idx  <= w_idx_nxt;
            r_dsel <= ~(DIGITS'(1) << w_idx_nxt);
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    assign w_dig_raw = r_q[{r_idx, 2'b00} +: 4];
`ifdef FREQM_BLANK_EN
    logic w_hi_zero;
    assign w_hi_zero = (r_q >> {r_idx, 2'b00}) == '0;
    assign bus.DIG   = (r_idx != '0 && !r_ovf_q && w_hi_zero) ? 4'hF : w_dig_raw;
`else
    assign bus.DIG   = w_dig_raw;
`endif
    assign bus.Q    = r_q;
    assign bus.OVF  = r_ovf_q;
    assign bus.RDY  = r_rdy;
    assign bus.DSEL = r_dsel;
endmodule

// File: tb/tb_freqm_counter.sv
// tb_freqm_counter: scoreboard bench for freqm_counter (DIGITS=3, GATE_CYC=80, SCAN_DIV=4)
module tb_freqm_counter;
    localparam int G = 80;
`ifdef FREQM_BLANK_EN
    localparam logic [3:0] BL = 4'hF;
`else
    localparam logic [3:0] BL = 4'h0;
`endif

    typedef struct {
        logic [11:0] q;
        logic        ovf;
        bit          cq;
        bit          co;
    } exp_t;

    logic clk = 1'b0;
    logic r0 = 1'b0;
    bit   fx_en = 1'b0;
    int   per = 8;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy_n = 0;
    int   last_rdy = 0;
    int   gap = 0;
    exp_t sb[$];

    freqm_counter_if #(.DIGITS(3)) bus();

    freqm_counter #(.DIGITS(3), .GATE_CYC(G), .SCAN_DIV(4)) dut (
        .CLK (clk),
        .R0  (r0),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] q, input logic ovf, input bit cq, input bit co);
        exp_t e;
        e.q = q; e.ovf = ovf; e.cq = cq; e.co = co;
        sb.push_back(e);
    endtask

    task automatic wait_rdy(input int n, input int lim);
        int t = rdy_n + n;
        for (int i = 0; i < lim && rdy_n < t; i++) begin
            @(negedge clk);
            #1;
        end
        if (rdy_n < t) chk("rdy_timeout", rdy_n, t);
    endtask

    // FX generator: square wave of period per, held low while disabled
    initial begin
        int ph = 0;
        bus.FX = 1'b0;
        forever begin
            @(negedge clk);
            if (!fx_en) begin
                ph = 0;
                bus.FX = 1'b0;
            end else begin
                bus.FX = (ph < per / 2);
                ph = (ph + 1 >= per) ? 0 : ph + 1;
            end
        end
    end

    // monitor: every RDY pulse pops one expected result
    always @(negedge clk) begin
        if (bus.RDY) begin
            exp_t e;
            rdy_n = rdy_n + 1;
            gap = cyc - last_rdy;
            last_rdy = cyc;
            if (sb.size() == 0) chk("rdy_unexp", 1, 0);
            else begin
                e = sb.pop_front();
                if (e.cq) chk("q", bus.Q, e.q);
                if (e.co) chk("ovf", bus.OVF, e.ovf);
            end
        end
    end

    initial begin
        int c0;
        int saved;
        bit found;
        logic [2:0] prev;
        logic [2:0] ed;
        logic [3:0] exp_dig [3];
        bus.RANGE = 2'd0;
        bus.HOLD = 1'b0;
        #1 r0 = 1'b1;
        #1;
        chk("rst_q", bus.Q, 0);
        chk("rst_ovf", bus.OVF, 0);
        chk("rst_rdy", bus.RDY, 0);
        chk("rst_dsel", bus.DSEL, 3'b110);
        chk("rst_dig", bus.DIG, 0);
        repeat (3) @(negedge clk);
        r0 = 1'b0;
        fx_en = 1'b1;
        c0 = cyc;
        push(12'h010, 1'b0, 1, 1);
        push(12'h010, 1'b0, 1, 1);
        wait_rdy(1, 200);
        chk("first_rdy", last_rdy - c0, G + 2);
        wait_rdy(1, 200);
        chk("gap_r0", gap, G + 2);
        repeat (20) @(negedge clk);
        #1 bus.RANGE = 2'd1;
        push(12'h010, 1'b0, 1, 1);
        push(12'h100, 1'b0, 1, 1);
        wait_rdy(1, 200);
        wait_rdy(1, 1000);
        chk("gap_r1", gap, 10 * G + 2);
        bus.RANGE = 2'd2;
        per = 4;
        push(12'h999, 1'b1, 1, 1);
        wait_rdy(1, 8200);
        chk("gap_r2", gap, 100 * G + 2);
        bus.RANGE = 2'd0;
        per = 8;
        push(12'h000, 1'b0, 0, 1);
        push(12'h010, 1'b0, 1, 1);
        wait_rdy(2, 300);
        bus.HOLD = 1'b1;
        per = 4;
        saved = rdy_n;
        repeat (170) @(negedge clk);
        #1;
        chk("hold_q", bus.Q, 12'h010);
        chk("hold_ovf", bus.OVF, 0);
        chk("hold_rdy", rdy_n, saved);
        bus.HOLD = 1'b0;
        push(12'h020, 1'b0, 1, 1);
        wait_rdy(1, 200);
        exp_dig[0] = 4'h0;
        exp_dig[1] = 4'h2;
        exp_dig[2] = BL;
        found = 1'b0;
        prev = bus.DSEL;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = (bus.DSEL == 3'b110) && (prev != 3'b110);
            prev = bus.DSEL;
        end
        if (!found) chk("scan_sync", 0, 1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            ed = ~(3'b001 << (k / 4));
            chk("scan_dsel", bus.DSEL, ed);
            chk("scan_dig", bus.DIG, exp_dig[k / 4]);
        end
        repeat (30) @(negedge clk);
        #1 r0 = 1'b1;
        fx_en = 1'b0;
        #1;
        chk("mrst_q", bus.Q, 0);
        chk("mrst_ovf", bus.OVF, 0);
        chk("mrst_rdy", bus.RDY, 0);
        chk("mrst_dsel", bus.DSEL, 3'b110);
        chk("mrst_dig", bus.DIG, 0);
        repeat (3) @(negedge clk);
        r0 = 1'b0;
        fx_en = 1'b1;
        c0 = cyc;
        push(12'h020, 1'b0, 1, 1);
        wait_rdy(1, 200);
        chk("mrst_first_rdy", last_rdy - c0, G + 2);
        chk("sb_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
